// File: rtl/result_packer_pkg.sv
// Shared types and width defaults for the result packer.
// Consumers: result_packer, result_packer_outreg.
package result_packer_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int ELEM_WIDTH_DEF = 32;

  function automatic int lanes_of(input int dw, input int ew);
    return dw / ew;
  endfunction

  localparam int LANES_DEF = lanes_of(DATA_WIDTH_DEF, ELEM_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/result_packer_outreg.sv
// Single-entry output register with valid/ready hold.
// Data stays stable while valid is high and ready is low.
module result_packer_outreg
  import result_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_free
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/result_packer.sv
// Packs ELEM_WIDTH results into DATA_WIDTH beats for the DMA stream.
// Define RESULT_PACKER_RELU_EN to clamp negative elements to zero.
module result_packer
  import result_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ELEM_WIDTH = ELEM_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           num_elems,
  input  logic [ELEM_WIDTH-1:0] s_axis_res_tdata,
  input  logic                  s_axis_res_tvalid,
  output logic                  s_axis_res_tready,
  output logic [DATA_WIDTH-1:0] m_axis_write_data_tdata,
  output logic                  m_axis_write_data_tvalid,
  input  logic                  m_axis_write_data_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);

  localparam int LANES = lanes_of(DATA_WIDTH, ELEM_WIDTH);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_num;
  logic [31:0]           r_elem_cnt;
  logic [LW-1:0]         r_lane_cnt;
  logic [DATA_WIDTH-1:0] r_asm;
  logic                  r_pend;

  logic [ELEM_WIDTH-1:0] w_elem;
  logic [DATA_WIDTH-1:0] w_beat;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_cmp;
  logic                  w_free;
  logic                  w_load;
  logic                  w_out_valid;

`ifdef RESULT_PACKER_RELU_EN
  assign w_elem = s_axis_res_tdata[ELEM_WIDTH-1] ? '0 : s_axis_res_tdata;
`else
  assign w_elem = s_axis_res_tdata;
`endif

  assign s_axis_res_tready = (r_state == PACK) && !r_pend;
  assign w_hs   = s_axis_res_tready && s_axis_res_tvalid;
  assign w_last = (r_elem_cnt + 32'd1) == r_num;
  assign w_cmp  = w_hs && (w_last || (r_lane_cnt == LAST_LANE));

  always_comb begin
    w_beat = r_asm;
    w_beat[r_lane_cnt*ELEM_WIDTH +: ELEM_WIDTH] = w_elem;
  end

  // A pending beat lives in r_asm; input is stalled while it waits.
  assign w_load      = w_free && (w_cmp || r_pend);
  assign w_load_data = r_pend ? r_asm : w_beat;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = (num_elems == '0) ? DONE : PACK;
      PACK:  if (w_hs && w_last) w_next = DRAIN;
      DRAIN: begin
        if (!r_pend && w_out_valid && m_axis_write_data_tready)
          w_next = DONE;
      end
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num      <= '0;
      r_elem_cnt <= '0;
      r_lane_cnt <= '0;
      r_asm      <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (r_state == IDLE && start && num_elems != '0) begin
        r_num      <= num_elems;
        r_elem_cnt <= '0;
        r_lane_cnt <= '0;
        r_asm      <= '0;
        r_pend     <= 1'b0;
      end
      if (w_hs) begin
        r_elem_cnt <= r_elem_cnt + 32'd1;
        r_lane_cnt <= w_cmp ? '0 : r_lane_cnt + LW'(1);
        if (!w_cmp) begin
          r_asm <= w_beat;
        end else if (w_free) begin
          r_asm <= '0;
        end else begin
          r_asm  <= w_beat;
          r_pend <= 1'b1;
        end
      end else if (r_pend && w_free) begin
        r_pend <= 1'b0;
        r_asm  <= '0;
      end
    end
  end

  result_packer_outreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outreg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_load_data),
    .i_ready(m_axis_write_data_tready),
    .o_valid(w_out_valid),
    .o_data (m_axis_write_data_tdata),
    .o_free (w_free)
  );

  assign m_axis_write_data_tvalid = w_out_valid;
  assign busy      = (r_state == PACK) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign start_err = start && busy && !rst;

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: directed jobs plus random jobs
// with random input gaps and output backpressure.
module tb_result_packer;

  localparam int DW = 128;
  localparam int EW = 32;
  localparam int L  = DW / EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   num_elems;
  logic [EW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          start_err;

  result_packer dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .num_elems               (num_elems),
    .s_axis_res_tdata        (s_tdata),
    .s_axis_res_tvalid       (s_tvalid),
    .s_axis_res_tready       (s_tready),
    .m_axis_write_data_tdata (m_tdata),
    .m_axis_write_data_tvalid(m_tvalid),
    .m_axis_write_data_tready(m_ready),
    .busy                    (busy),
    .done                    (done),
    .start_err               (start_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = -10;
  int job_beats = 0;
  int acc_cnt = 0;
  int rdy_mode = 0;
  logic [DW-1:0] sb[$];
  logic [EW-1:0] elems[$];
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'b0;
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: element k lands in beat k/L, lane k%L; tail lanes are zero.
  task automatic push_expected(input int n);
    logic [DW-1:0] b;
    logic [EW-1:0] v;
    for (int k = 0; k < n; k += L) begin
      b = '0;
      for (int j = 0; j < L && k + j < n; j++) begin
        v = elems[k+j];
`ifdef RESULT_PACKER_RELU_EN
        if ($signed(v) < 0) v = '0;
`endif
        b = b | (DW'(v) << (EW * j));
      end
      sb.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else if (m_tvalid) begin
      if (hold_v) chk("tdata_stable", m_tdata, hold_d);
      if (m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
        end else begin
          chk("beat", m_tdata, sb.pop_front());
        end
        last_hs = cyc;
        job_beats++;
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = m_tdata;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start_err"}, start_err, 0);
  endtask

  task automatic run_job(input int n, input int abort_at,
                         input bit do_err, input bit gaps);
    int  i = 0;
    int  w = 0;
    int  dcyc = 0;
    int  dcnt = 0;
    bit  hs;
    bit  errd = 0;
    bit  err_chk = 0;
    bit  got = 0;
    push_expected(n);
    job_beats = 0;
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    num_elems = n;
    s_tvalid = 1'b1;
    s_tdata = elems[0];
    @(negedge clk);
    chk("idle_no_accept", s_tready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < n && w < 2000) begin
      s_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata = elems[i];
      if (do_err && i == 1 && !errd) begin
        start = 1'b1;
        num_elems = 7;
        errd = 1;
        err_chk = 1;
      end
      @(negedge clk);
      hs = s_tvalid && s_tready;
      if (err_chk) begin
        chk("start_err", start_err, 1);
        err_chk = 0;
      end
      @(posedge clk); #1;
      w++;
      start = 1'b0;
      if (hs) begin
        i++;
        acc_cnt = i;
      end
      if (abort_at > 0 && i == abort_at) begin
        rst = 1'b1;
        s_tvalid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_rst");
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (done) dcnt++;
        end
        chk("no_done_after_rst", dcnt, 0);
        return;
      end
    end
    s_tvalid = 1'b0;
    chk("elems_accepted", i, n);
    for (w = 0; w < 500 && !got; w++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        dcyc = cyc;
      end
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_latency", dcyc, last_hs + 1);
      chk("beat_count", job_beats, (n + L - 1) / L);
      chk("sb_empty", sb.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic run_zero();
    @(posedge clk); #1;
    start = 1'b1;
    num_elems = 0;
    @(negedge clk);
    chk("zero_busy_a", busy, 0);
    chk("zero_done_early", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy_b", busy, 0);
    chk("zero_tvalid", m_tvalid, 0);
    @(negedge clk);
    chk("zero_done_off", done, 0);
    chk("zero_busy_c", busy, 0);
  endtask

  task automatic fill_seq(input int n, input logic [EW-1:0] base);
    elems.delete();
    for (int k = 0; k < n; k++) elems.push_back(base + EW'(k));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_elems = '0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    fill_seq(8, 32'd1);
    run_job(8, -1, 0, 0);

    fill_seq(5, 32'd1);
    run_job(5, -1, 0, 0);

    elems.delete();
    elems.push_back(32'hFFFF_FFFF);
    elems.push_back(32'd7);
    elems.push_back(32'h8000_0000);
    elems.push_back(32'd2);
    run_job(4, -1, 0, 0);

    run_zero();

    rdy_mode = 1;
    @(posedge clk);
    fill_seq(12, 32'd1);
    fork
      run_job(12, -1, 0, 0);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", acc_cnt, 8);
        chk("bp_s_tready", s_tready, 0);
        chk("bp_tvalid", m_tvalid, 1);
        rdy_mode = 0;
      end
    join

    fill_seq(8, 32'h10);
    run_job(8, 3, 1, 0);
    fill_seq(4, 32'hA0);
    run_job(4, -1, 0, 0);

    rdy_mode = 2;
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 19);
      elems.delete();
      for (int k = 0; k < n; k++) elems.push_back($urandom);
      run_job(n, -1, 0, bit'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    run_zero();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
